// File: rtl/detection_combination_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : detection_combination_unit_pkg
// Brief  : Shared constants, descriptor types, sprite bitmaps and the
//          per-entity tile hit detector for detection_combination_unit.
// Rev    : 1.0  initial release
// ============================================================================
package detection_combination_unit_pkg;

  localparam int UPSCALE  = 5;
  localparam int TILE_PX  = 8 * UPSCALE;
  localparam int SCREEN_H = 16;
  localparam int SCREEN_V = 12;

  localparam logic [9:0] H_PIXELS = 10'(SCREEN_H * TILE_PX);
  localparam logic [9:0] V_PIXELS = 10'(SCREEN_V * TILE_PX);

  // 14-bit entity word field offsets
  localparam int ENT_ID_LSB     = 10;
  localparam int ENT_ORIENT_LSB = 8;
  localparam int ENT_COL_LSB    = 0;
  localparam int ENT_ROW_LSB    = 4;

  localparam logic [3:0] UNUSED_ID = 4'hF;
  localparam logic [8:0] NO_ENTITY = 9'h1FF;

  typedef enum logic [1:0] {
    ORIENT_0   = 2'b00,
    ORIENT_90  = 2'b01,
    ORIENT_180 = 2'b10,
    ORIENT_270 = 2'b11
  } orient_e;

  typedef struct packed {
    logic [2:0] line;
    logic [3:0] id;
    logic [1:0] orient;
  } descriptor_t;

  // Native bitmap of one sprite; row r lives in bits [8r+7:8r], bit c = column c.
  function automatic logic [63:0] sprite_bitmap(input logic [3:0] id);
    case (id)
      4'h1:    return 64'hA55A24FFDB7E3C18;
      4'h2:    return 64'hFF7F3F1F0F070301;
      4'h3:    return 64'h55AA55AA0FF00FF0;
      4'h5:    return 64'h40800102040810E0;
      4'h6:    return 64'hF1DEBC9A78563412;
      default: return 64'h0;
    endcase
  endfunction

  // Multiply by the tile edge using shifts only (40 = 32 + 8).
  function automatic logic [10:0] times40(input logic [10:0] x);
    return (x << 5) + (x << 3);
  endfunction

  // Returns {hit, line, id, orient} for an entity spanning 'span' tiles
  // starting at (col,row). span = 0 disables the entity.
  function automatic logic [9:0] detect(input logic [3:0] id, input logic [1:0] orient,
                                        input logic [3:0] col, input logic [3:0] row,
                                        input logic [4:0] span, input logic flip,
                                        input logic [9:0] h, input logic [9:0] v);
    logic [10:0] x0, x1, y0;
    logic [4:0]  col_end;
    logic [9:0]  dy;
    logic [2:0]  line;
    logic        hit;
    col_end = {1'b0, col} + span;
    x0      = times40({7'b0, col});
    x1      = times40({6'b0, col_end});
    y0      = times40({7'b0, row});
    hit     = (id != UNUSED_ID) && (span != 5'd0) && (row < 4'(SCREEN_V)) &&
              ({1'b0, h} >= x0) && ({1'b0, h} < x1) &&
              ({1'b0, v} >= y0) && ({1'b0, v} < y0 + 11'(TILE_PX));
    dy      = v - y0[9:0];
    // Divide-free line index: count how many sprite-pixel boundaries lie below dy.
    line = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (dy >= 10'(UPSCALE * k)) line = 3'(k);
    end
    if (flip) line = ~line;
    return {hit, line, id, orient};
  endfunction

  // Detector wrapper for the single-tile 14-bit entity format.
  function automatic logic [9:0] detect14(input logic [13:0] ent, input logic flip,
                                          input logic [9:0] h, input logic [9:0] v);
    return detect(ent[ENT_ID_LSB +: 4], ent[ENT_ORIENT_LSB +: 2],
                  ent[ENT_COL_LSB +: 4], ent[ENT_ROW_LSB +: 4], 5'd1, flip, h, v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/detection_combination_unit_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module : sprite_rom
// Brief  : Sprite bitmap ROM with orientation transform; registered row out.
// Rev    : 1.0  initial release
// ============================================================================
module sprite_rom
  import detection_combination_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sprite_ID,
  input  logic [1:0] orientation,
  input  logic [2:0] line_index,
  output logic [7:0] data
);

  logic [63:0] bitmap;
  logic [7:0]  row_next;

  // Pick each output column from the native bitmap according to orientation
  // (7-x on a 3-bit index is just ~x).
  always_comb begin
    bitmap   = sprite_bitmap(sprite_ID);
    row_next = 8'h00;
    for (int c = 0; c < 8; c++) begin
      case (orient_e'(orientation))
        ORIENT_0:   row_next[c] = bitmap[{line_index, 3'(c)}];
        ORIENT_90:  row_next[c] = bitmap[{~3'(c), line_index}];
        ORIENT_180: row_next[c] = bitmap[{~line_index, ~3'(c)}];
        default:    row_next[c] = bitmap[{3'(c), ~line_index}];
      endcase
    end
  end

  // Output register; cleared while reset is high.
  always_ff @(posedge clk) begin
    if (reset) data <= 8'h00;
    else       data <= row_next;
  end

endmodule
`default_nettype wire

// File: rtl/detection_combination_unit.sv
`default_nettype none
// ============================================================================
// Module : detection_combination_unit
// Brief  : Per-pixel entity detector with priority select and sprite fetch.
//          out_entity is one cycle behind the counters, sprite_data two.
// Rev    : 1.0  initial release
// ============================================================================
module detection_combination_unit
  import detection_combination_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] entity_1,
  input  logic [13:0] entity_2,
  input  logic [13:0] entity_3,
  input  logic [13:0] entity_4,
  input  logic [13:0] entity_5,
  input  logic [13:0] entity_6,
  input  logic [17:0] entity_7_Array,
  input  logic [13:0] entity_8_Flip,
  input  logic [13:0] entity_9_Flip,
  input  logic [9:0]  counter_V,
  input  logic [9:0]  counter_H,
  output logic [8:0]  out_entity,
  output logic [7:0]  sprite_data
);

  logic [9:0]  cand [9];
  logic [8:0]  next_entity;
  descriptor_t desc;

  // Run all nine detectors and keep the lowest-numbered hitting entity.
  always_comb begin
    cand[0] = detect14(entity_1, 1'b0, counter_H, counter_V);
    cand[1] = detect14(entity_2, 1'b0, counter_H, counter_V);
    cand[2] = detect14(entity_3, 1'b0, counter_H, counter_V);
    cand[3] = detect14(entity_4, 1'b0, counter_H, counter_V);
    cand[4] = detect14(entity_5, 1'b0, counter_H, counter_V);
    cand[5] = detect14(entity_6, 1'b0, counter_H, counter_V);
    cand[6] = detect(entity_7_Array[17:14], entity_7_Array[13:12],
                     entity_7_Array[7:4], entity_7_Array[11:8],
                     {1'b0, entity_7_Array[3:0]}, 1'b0, counter_H, counter_V);
    cand[7] = detect14(entity_8_Flip, 1'b1, counter_H, counter_V);
    cand[8] = detect14(entity_9_Flip, 1'b1, counter_H, counter_V);
    next_entity = NO_ENTITY;
    for (int i = 8; i >= 0; i--) begin
      if (cand[i][9]) next_entity = cand[i][8:0];
    end
    if (counter_H >= H_PIXELS || counter_V >= V_PIXELS) next_entity = NO_ENTITY;
  end

  // First pipeline stage: registered descriptor.
  always_ff @(posedge clk) begin
    if (reset) out_entity <= NO_ENTITY;
    else       out_entity <= next_entity;
  end

  assign desc = descriptor_t'(out_entity);

  sprite_rom u_sprite_rom (
    .clk         (clk),
    .reset       (reset),
    .sprite_ID   (desc.id),
    .orientation (desc.orient),
    .line_index  (desc.line),
    .data        (sprite_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_detection_combination_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_detection_combination_unit
// Brief  : Directed self-checking bench for detection_combination_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_detection_combination_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6;
  logic [17:0] entity_7_Array;
  logic [13:0] entity_8_Flip, entity_9_Flip;
  logic [9:0]  counter_V, counter_H;
  logic [8:0]  out_entity;
  logic [7:0]  sprite_data;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] OFF14 = 14'h3C00;
  localparam logic [17:0] OFF18 = 18'h3C000;

  detection_combination_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entity_1       (entity_1),
    .entity_2       (entity_2),
    .entity_3       (entity_3),
    .entity_4       (entity_4),
    .entity_5       (entity_5),
    .entity_6       (entity_6),
    .entity_7_Array (entity_7_Array),
    .entity_8_Flip  (entity_8_Flip),
    .entity_9_Flip  (entity_9_Flip),
    .counter_V      (counter_V),
    .counter_H      (counter_H),
    .out_entity     (out_entity),
    .sprite_data    (sprite_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ent(input string tag, input logic [8:0] exp);
    checks++;
    assert (out_entity === exp) else begin
      errors++;
      $error("FAIL %s out_entity got %h expected %h", tag, out_entity, exp);
    end
  endtask

  task automatic chk_spr(input string tag, input logic [7:0] exp);
    checks++;
    assert (sprite_data === exp) else begin
      errors++;
      $error("FAIL %s sprite_data got %h expected %h", tag, sprite_data, exp);
    end
  endtask

  // Apply position, then check descriptor after 1 edge and sprite row after 2.
  task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic [8:0] exp_ent, input logic [7:0] exp_spr);
    counter_H = h;
    counter_V = v;
    step();
    chk_ent(tag, exp_ent);
    step();
    chk_spr(tag, exp_spr);
  endtask

  initial begin
    reset          = 1'b1;
    entity_1       = {4'h1, 2'b00, 8'h23};
    entity_2       = OFF14;
    entity_3       = OFF14;
    entity_4       = OFF14;
    entity_5       = OFF14;
    entity_6       = OFF14;
    entity_7_Array = OFF18;
    entity_8_Flip  = OFF14;
    entity_9_Flip  = OFF14;
    counter_H      = 10'd120;
    counter_V      = 10'd85;

    // Reset held with a live hit present
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ent("reset_ent", 9'h1FF);
      chk_spr("reset_spr", 8'h00);
    end
    reset = 1'b0;
    step();
    chk_ent("release_ent", 9'h044);
    chk_spr("release_spr_still_idle", 8'h00);
    step();
    chk_spr("release_spr", 8'h3C);

    // Tile edges for entity_1 at col 3 row 2
    probe("e1_right_edge", 10'd160, 10'd85, 9'h1FF, 8'h00);
    probe("e1_bottom_edge", 10'd120, 10'd120, 9'h1FF, 8'h00);
    probe("e1_corner_last", 10'd159, 10'd119, 9'h1C4, 8'hA5);

    // Priority: entity_1 beats entity_3 on the same tile
    entity_3 = {4'h2, 2'b00, 8'h23};
    probe("prio_e1", 10'd120, 10'd85, 9'h044, 8'h3C);
    entity_1 = OFF14;
    probe("prio_e3", 10'd120, 10'd85, 9'h048, 8'h03);
    entity_3 = OFF14;
    probe("all_unused", 10'd120, 10'd85, 9'h1FF, 8'h00);

    // entity_7 run: cols 14..17 clipped to 14..15 on row 0
    entity_7_Array = {4'h5, 2'b00, 8'h0E, 4'd4};
    probe("e7_start", 10'd560, 10'd0, 9'h014, 8'hE0);
    probe("e7_before", 10'd559, 10'd0, 9'h1FF, 8'h00);
    probe("e7_last_px", 10'd639, 10'd0, 9'h014, 8'hE0);
    probe("e7_offscreen", 10'd640, 10'd0, 9'h1FF, 8'h00);
    probe("e7_row1", 10'd600, 10'd40, 9'h1FF, 8'h00);
    entity_7_Array[3:0] = 4'd0;
    probe("e7_count0", 10'd600, 10'd0, 9'h1FF, 8'h00);
    entity_7_Array = OFF18;

    // Flipped entity_8 at tile 0, orientation 10
    entity_8_Flip = {4'h3, 2'b10, 8'h00};
    probe("e8_flip", 10'd0, 10'd0, 9'h1CE, 8'h0F);
    entity_8_Flip = OFF14;

    // Flipped entity_9 at col 1 row 1, last sprite row maps to line 0
    entity_9_Flip = {4'h2, 2'b00, 8'h11};
    probe("e9_flip", 10'd45, 10'd79, 9'h008, 8'h01);
    entity_9_Flip = OFF14;

    // Orientations 01 and 11 on ID 6, line 2
    entity_2 = {4'h6, 2'b01, 8'h00};
    probe("orient01", 10'd3, 10'd12, 9'h099, 8'h66);
    entity_2 = {4'h6, 2'b11, 8'h00};
    probe("orient11", 10'd3, 10'd12, 9'h09B, 8'hAA);
    probe("offscreen_v", 10'd3, 10'd480, 9'h1FF, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
